// File: rtl/btn_pkg.sv
// Shared FSM state encoding for the button/reset controller.
// hold_stage is driven directly from the state, so the two must stay aligned.
package btn_pkg;

   localparam logic [1:0] STAGE_IDLE    = 2'd0;
   localparam logic [1:0] STAGE_PRESSED = 2'd1;
   localparam logic [1:0] STAGE_HELD    = 2'd2;
   localparam logic [1:0] STAGE_REBOOT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = STAGE_IDLE,
      ST_PRESSED = STAGE_PRESSED,
      ST_HELD    = STAGE_HELD,
      ST_REBOOT  = STAGE_REBOOT
   } btn_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for an active-low push button.
// btn_level is registered; btn_rise/btn_fall flag the edge on which btn_level toggles.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
   input  logic clk48,
   input  logic rst_n,
   input  logic btn_raw_n,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_q;
   logic          level_d;
   logic          differ;
   logic          expire;

   // Sample is inverted at the pin so 1 means pressed from here on.
   always_comb begin
      differ  = (sync_q[1] != level_q);
      expire  = differ && (cnt_q == CNT_LAST);
      cnt_d   = (differ && !expire) ? cnt_q + 1'b1 : '0;
      level_d = expire ? ~level_q : level_q;
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], ~btn_raw_n};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = expire & ~level_q;
   assign btn_fall  = expire & level_q;

endmodule

// File: rtl/btn_reset_ctrl.sv
// User button controller: short/long press classification and a sticky
// bootloader reboot request after a very long hold.
module btn_reset_ctrl
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 48000,
   parameter int unsigned LONG_CYCLES     = 24000000,
   parameter int unsigned REBOOT_CYCLES   = 96000000
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic       usr_btn,
   output logic       btn_level,
   output logic       short_press,
   output logic       long_press,
   output logic       reboot_n,
   output logic [1:0] hold_stage
);

   localparam int unsigned HW = $clog2(REBOOT_CYCLES);
   localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REBOOT_LAST = HW'(REBOOT_CYCLES - 1);

   if (REBOOT_CYCLES <= LONG_CYCLES) begin : g_bad_thresholds
      $error("btn_reset_ctrl: REBOOT_CYCLES must exceed LONG_CYCLES");
   end

   logic       level;
   logic       lvl_rise;
   logic       lvl_fall;
   btn_state_e state_q;
   btn_state_e state_d;
   logic [HW-1:0] hold_cnt_q;
   logic [HW-1:0] hold_cnt_d;
   logic       short_q;
   logic       short_d;
   logic       long_q;
   logic       long_d;
   logic       reboot_n_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk48     (clk48),
      .rst_n     (rst_n),
      .btn_raw_n (usr_btn),
      .btn_level (level),
      .btn_rise  (lvl_rise),
      .btn_fall  (lvl_fall)
   );

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      short_d    = 1'b0;
      long_d     = 1'b0;

      if ((state_q == ST_PRESSED || state_q == ST_HELD) && level && hold_cnt_q != REBOOT_LAST) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end

      // Release is tested before the thresholds so it wins a same-cycle tie.
      case (state_q)
         ST_IDLE: begin
            if (lvl_rise) begin
               state_d    = ST_PRESSED;
               hold_cnt_d = '0;
            end
         end
         ST_PRESSED: begin
            if (lvl_fall) begin
               short_d = 1'b1;
               state_d = ST_IDLE;
            end else if (hold_cnt_q == LONG_LAST) begin
               long_d  = 1'b1;
               state_d = ST_HELD;
            end
         end
         ST_HELD: begin
            if (lvl_fall) begin
               state_d = ST_IDLE;
            end else if (hold_cnt_q == REBOOT_LAST) begin
               state_d = ST_REBOOT;
            end
         end
         ST_REBOOT: state_d = ST_REBOOT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         reboot_n_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         short_q    <= short_d;
         long_q     <= long_d;
         reboot_n_q <= (state_q != ST_REBOOT);
      end
   end

   assign btn_level   = level;
   assign short_press = short_q;
   assign long_press  = long_q;
   assign reboot_n    = reboot_n_q;
   assign hold_stage  = state_q;

endmodule
